neuron_mac_stage: RTL and testbench
===================================

Name: neuron_mac_stage

Overview:
- Sequential multiply-accumulate neuron front end.
- Consumes a stream of N_INPUTS (x, w) pairs plus a bias and produces one saturated signed Q4.4 pre-activation z_value.
- z_value drives the activation-function stage (LUT plus interpolator) directly downstream.
- One instance per neuron; the layer controller streams the operands in.

Parameters:
- N_INPUTS, 2, number of (x, w) pairs per neuron evaluation (must be ≥1).
- DATA_W, 8, width of x, w, bias and z_value (signed, two's complement).
- FRAC_W, 4, fractional bits of every operand and of the result (Q4.4 at the defaults).
- ACC_W, 20, accumulator width; must be ≥ 2*DATA_W + clog2(N_INPUTS+1) + 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  x_in/w_in (and bias_in on the first element) are valid.
- in_ready  out  1  stage accepts an element this cycle.
- x_in  in  DATA_W  signed input activation, Q4.4.
- w_in  in  DATA_W  signed weight, Q4.4.
- bias_in  in  DATA_W  signed bias, Q4.4; sampled only on the first accepted element.
- z_valid  out  1  z_value holds a result.
- z_ready  in  1  downstream consumes z_value.
- z_value  out  DATA_W  signed saturated pre-activation, Q4.4.
- busy  out  1  high in ACC or OUT.

Behaviour:
- Reset (rst==0 at a clk edge) takes effect in that cycle regardless of state or handshake activity:
  - state := IDLE, count := 0, acc := 0.
  - z_valid := 0, z_value := 0, busy := 0.
  - in_ready is 1 from the first cycle after reset is released.
- Accept handshake: an element is accepted when in_valid && in_ready.
- in_ready = (state != OUT).
- States:
  - IDLE: accepted element → acc := sext(x*w) + (sext(bias_in) << FRAC_W); count := 1; next state ACC, or OUT if N_INPUTS==1.
  - ACC: accepted element → acc += sext(x*w); count += 1; when count reaches N_INPUTS, next state is OUT.
  - OUT: z_valid=1 and z_value is held stable. When z_ready is asserted: z_valid := 0, count := 0, acc := 0, next state IDLE. No element is accepted in OUT.
- Arithmetic:
  - Product is a full 2*DATA_W signed value, Q8.8.
  - Accumulator is ACC_W signed and never overflows under the width rule above.
  - Result: r = acc >>> FRAC_W (arithmetic shift, truncate toward −inf).
  - Saturation: r > 127 → 0x7F; r < −128 → 0x80; otherwise r[DATA_W-1:0].
- Latency: z_valid rises on the clock edge that accepts the Nth element, so it is visible the following cycle. Minimum period is N_INPUTS+1 cycles per neuron.
- in_valid low in IDLE/ACC: the stage holds its state and count; gaps are allowed.
- z_ready high outside OUT: ignored.
- z_ready low in OUT: the stage holds indefinitely; z_value does not change.
- Reset mid-operation (ACC or OUT): the partial sum is discarded and no z_valid pulse is produced for that vector.

Optional Feature:
- Macro: NEURON_MAC_ROUND_EN.
- Defined: before the shift, r = (acc + (1 << (FRAC_W-1))) >>> FRAC_W, i.e. round half up; saturation applies after rounding.
- Undefined: truncation as specified above.
- Handshake and latency are identical in both builds.

Test Plan:
- Nominal: x=(0x10,0x10), w=(0x20,0x20), bias=0xF0 → z_valid one cycle after the 2nd accept; z_value=0x30 (2+2−1=3.0).
- Positive saturation: x=(0x7F,0x7F), w=(0x7F,0x7F), bias=0x00 → z_value=0x7F.
- Negative saturation: x=(0x80,0x80), w=(0x7F,0x7F), bias=0x00 → z_value=0x80.
- Rounding: x=(0x01,0x00), w=(0x08,0x00), bias=0 → z_value=0x00 without the macro; 0x01 with NEURON_MAC_ROUND_EN.
- Backpressure/gaps:
  - in_valid low for 2 cycles between elements → same result as nominal.
  - z_ready held low for 3 cycles → z_value stable, in_ready=0.
  - When z_ready rises → z_valid falls the next cycle and in_ready returns to 1.
- Reset mid-op: accept 1 element, then rst=0 for 1 cycle → busy=0, z_valid=0. A fresh nominal vector then yields 0x30 with no stale contribution.

Source files
------------

// File: rtl/neuron_mac_stage.sv
// neuron_mac_stage: sequential multiply-accumulate front end of one neuron.
// Accepts N_INPUTS (x, w) pairs (bias sampled with the first pair) and
// produces one saturated signed Q(DATA_W-FRAC_W).FRAC_W pre-activation.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   in_valid/ready  element handshake for x_in, w_in (and bias_in on first)
//   x_in, w_in      signed operands, bias_in signed bias
//   z_valid/ready   result handshake, z_value saturated result
//   busy            high while accumulating or holding a result
//
// Build option: define NEURON_MAC_ROUND_EN to round half up before the
// final shift instead of truncating toward -inf.
module neuron_mac_stage #(
  parameter int unsigned N_INPUTS = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned ACC_W    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] bias_in,
  output logic              z_valid,
  input  logic              z_ready,
  output logic [DATA_W-1:0] z_value,
  output logic              busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(N_INPUTS + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      z_valid_q, z_valid_d;
  logic [DATA_W-1:0]         z_value_q, z_value_d;
  logic                      busy_q, busy_d;
  logic                      in_ready_q, in_ready_d;

  logic signed [DATA_W-1:0]  x_s, w_s;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, acc_sum, rnd, r;
  logic [CNT_W-1:0]          count_inc;
  logic                      accept, last;

  // Datapath: full-width product, sign-extended operands and saturated result
  always_comb begin
    x_s       = x_in;
    w_s       = w_in;
    prod      = x_s * w_s;
    prod_ext  = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext  = {{(ACC_W - DATA_W - FRAC_W){bias_in[DATA_W-1]}}, bias_in, {FRAC_W{1'b0}}};
    // First element seeds the accumulator with the bias aligned to Q8.8
    acc_sum   = (state_q == S_IDLE) ? (bias_ext + prod_ext) : (acc_q + prod_ext);
`ifdef NEURON_MAC_ROUND_EN
    rnd       = acc_sum + ACC_W'(1 << (FRAC_W - 1));
`else
    rnd       = acc_sum;
`endif
    r         = rnd >>> FRAC_W;
    count_inc = (state_q == S_IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
    last      = (count_inc == CNT_W'(N_INPUTS));
    accept    = in_valid && in_ready_q;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    z_valid_d = z_valid_q;
    z_value_d = z_value_q;

    unique case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
          acc_d   = acc_sum;
          count_d = count_inc;
          state_d = S_ACC;
          if (last) begin
            state_d   = S_OUT;
            z_valid_d = 1'b1;
            if (r > SAT_MAX) begin
              z_value_d = SAT_MAX[DATA_W-1:0];
            end else if (r < SAT_MIN) begin
              z_value_d = SAT_MIN[DATA_W-1:0];
            end else begin
              z_value_d = r[DATA_W-1:0];
            end
          end
        end
      end
      S_OUT: begin
        if (z_ready) begin
          state_d   = S_IDLE;
          z_valid_d = 1'b0;
          count_d   = '0;
          acc_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d != S_OUT);
  end

  // State register; in_ready comes up as 1 straight out of reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      z_valid_q  <= 1'b0;
      z_value_q  <= '0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      z_valid_q  <= z_valid_d;
      z_value_q  <= z_value_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign z_valid  = z_valid_q;
  assign z_value  = z_value_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_neuron_mac_stage.sv
// Directed bench for neuron_mac_stage at default parameters (N_INPUTS=2, Q4.4).
module tb_neuron_mac_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in, w_in, bias_in;
  logic       z_valid;
  logic       z_ready;
  logic [7:0] z_value;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  neuron_mac_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .bias_in  (bias_in),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .z_value  (z_value),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one element and hold it until accepted (bounded wait)
  task automatic send(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
    int waited;
    in_valid = 1'b1;
    x_in     = x;
    w_in     = w;
    bias_in  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    x_in     = 8'h00;
    w_in     = 8'h00;
    bias_in  = 8'h00;
  endtask

  // Check a presented result, optionally stall, then consume it
  task automatic collect(input string tag, input logic [7:0] exp, input int hold);
    chk({tag, "_zvalid"}, 32'(z_valid), 32'd1);
    chk({tag, "_zvalue"}, 32'(z_value), 32'(exp));
    chk({tag, "_inready_out"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy_out"}, 32'(busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_zvalue"}, 32'(z_value), 32'(exp));
      chk({tag, "_hold_zvalid"}, 32'(z_valid), 32'd1);
      chk({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
    end
    z_ready = 1'b1;
    step();
    z_ready = 1'b0;
    chk({tag, "_zvalid_drop"}, 32'(z_valid), 32'd0);
    chk({tag, "_inready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input string tag,
                         input logic [7:0] x0, input logic [7:0] w0,
                         input logic [7:0] x1, input logic [7:0] w1,
                         input logic [7:0] b, input logic [7:0] exp);
    send(x0, w0, b);
    chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
    chk({tag, "_zvalid_acc"}, 32'(z_valid), 32'd0);
    send(x1, w1, 8'h55);
    collect(tag, exp, 0);
  endtask

  logic [7:0] exp_rnd_pos, exp_rnd_neg;

  initial begin
`ifdef NEURON_MAC_ROUND_EN
    exp_rnd_pos = 8'h01;
    exp_rnd_neg = 8'h00;
`else
    exp_rnd_pos = 8'h00;
    exp_rnd_neg = 8'hFF;
`endif
    rst      = 1'b0;
    in_valid = 1'b0;
    z_ready  = 1'b0;
    x_in     = 8'h00;
    w_in     = 8'h00;
    bias_in  = 8'h00;

    // Reset state
    step();
    step();
    chk("rst_zvalid", 32'(z_valid), 32'd0);
    chk("rst_zvalue", 32'(z_value), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    chk("rst_inready", 32'(in_ready), 32'd1);
    step();
    chk("idle_inready", 32'(in_ready), 32'd1);

    // 1*2 + 1*2 - 1 = 3.0
    run_vec("nominal", 8'h10, 8'h20, 8'h10, 8'h20, 8'hF0, 8'h30);
    run_vec("pos_sat", 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h7F);
    run_vec("neg_sat", 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'h80);
    // 0x08/256 = 1/32: truncates to 0, rounds up to 1/16
    run_vec("round_pos", 8'h01, 8'h08, 8'h00, 8'h00, 8'h00, exp_rnd_pos);
    // -1/32: floors to -1/16, rounds half up to 0
    run_vec("round_neg", 8'hFF, 8'h08, 8'h00, 8'h00, 8'h00, exp_rnd_neg);
    // 3*-2 + 1*1 + 0.5 = -4.5
    run_vec("mixed", 8'h30, 8'hE0, 8'h10, 8'h10, 8'h08, 8'hB8);

    // Gaps between elements with z_ready high while not in OUT
    send(8'h10, 8'h20, 8'hF0);
    z_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_zvalid", 32'(z_valid), 32'd0);
      chk("gap_inready", 32'(in_ready), 32'd1);
    end
    z_ready = 1'b0;
    send(8'h10, 8'h20, 8'h00);
    // Offered elements during OUT must not be taken
    in_valid = 1'b1;
    x_in     = 8'h7F;
    w_in     = 8'h7F;
    collect("backpressure", 8'h30, 3);
    in_valid = 1'b0;
    step();
    chk("post_bp_busy", 32'(busy), 32'd0);

    // Reset mid-operation discards the partial sum
    send(8'h7F, 8'h7F, 8'h70);
    chk("midrst_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_zvalid", 32'(z_valid), 32'd0);
    chk("midrst_inready", 32'(in_ready), 32'd1);
    run_vec("after_rst", 8'h10, 8'h20, 8'h10, 8'h20, 8'hF0, 8'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
